// File: rtl/collatz_engine.sv
// collatz_engine
//   Multi-lane Collatz step counter. A call loads LANES independent values and
//   iterates each lane (x even -> x/2, x odd -> 3x+1) until it reaches 1, hits
//   an arithmetic overflow, exceeds the step limit, or was started at zero.
//   When every lane is finished, the engine pulses `finish` for one cycle and
//   presents the per-lane step counts and flags.
//
// Parameters
//   WIDTH     : bit width of each lane value
//   LANES     : number of independent lanes per call
//   MAX_STEPS : per-lane step limit (STEP_W = clog2(MAX_STEPS+1))
//
// Ports
//   clk        : single clock, rising edge
//   reset      : synchronous, active-low
//   start      : call request, honoured only while ready=1
//   ready      : engine can accept start (IDLE/DONE)
//   n          : lane i value in n[i*WIDTH +: WIDTH]
//   finish     : one-cycle pulse when all lanes are complete
//   return_val : lane i step count in return_val[i*STEP_W +: STEP_W]
//   ovf        : per-lane arithmetic overflow flag
//   timeout    : per-lane step-limit flag
//   bad_in     : per-lane zero-input flag
//
// Build option
//   COLLATZ_SHORTCUT_EN : odd steps compute (3x+1)>>1 and advance the count by
//                         two (clamped at MAX_STEPS). Final counts and flags of
//                         non-timeout lanes match the default build; only the
//                         number of cycles per call changes.
module collatz_engine #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned LANES     = 4,
  parameter int unsigned MAX_STEPS = 1024,
  localparam int unsigned STEP_W   = $clog2(MAX_STEPS + 1)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  output logic                    ready,
  input  logic [LANES*WIDTH-1:0]  n,
  output logic                    finish,
  output logic [LANES*STEP_W-1:0] return_val,
  output logic [LANES-1:0]        ovf,
  output logic [LANES-1:0]        timeout,
  output logic [LANES-1:0]        bad_in
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [STEP_W-1:0] MAX_CNT = STEP_W'(MAX_STEPS);

  state_t state_q, state_d;
  logic   ready_q, ready_d;
  logic   finish_q, finish_d;

  // Working state of the call in progress.
  logic [LANES-1:0][WIDTH-1:0]  x_q, x_d;
  logic [LANES-1:0][STEP_W-1:0] cnt_q, cnt_d;
  logic [LANES-1:0]             done_q, done_d;
  logic [LANES-1:0]             lane_ovf_q, lane_ovf_d;
  logic [LANES-1:0]             lane_to_q, lane_to_d;
  logic [LANES-1:0]             lane_bad_q, lane_bad_d;

  // Presented results: captured on RUN->DONE so a back-to-back call, which
  // restarts the working state immediately, cannot disturb values already
  // shown to the consumer.
  logic [LANES-1:0][STEP_W-1:0] res_cnt_q, res_cnt_d;
  logic [LANES-1:0]             res_ovf_q, res_ovf_d;
  logic [LANES-1:0]             res_to_q, res_to_d;
  logic [LANES-1:0]             res_bad_q, res_bad_d;

  logic                         accept;
  logic [WIDTH+1:0]             odd_next;

  assign accept = start & ready_q;

  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    cnt_d      = cnt_q;
    done_d     = done_q;
    lane_ovf_d = lane_ovf_q;
    lane_to_d  = lane_to_q;
    lane_bad_d = lane_bad_q;
    res_cnt_d  = res_cnt_q;
    res_ovf_d  = res_ovf_q;
    res_to_d   = res_to_q;
    res_bad_d  = res_bad_q;
    finish_d   = 1'b0;
    odd_next   = '0;

    unique case (state_q)
      IDLE, DONE: begin
        if (accept) begin
          state_d    = RUN;
          x_d        = n;
          cnt_d      = '0;
          done_d     = '0;
          lane_ovf_d = '0;
          lane_to_d  = '0;
          lane_bad_d = '0;
        end
      end

      RUN: begin
        if (&done_q) begin
          state_d   = DONE;
          finish_d  = 1'b1;
          res_cnt_d = cnt_q;
          res_ovf_d = lane_ovf_q;
          res_to_d  = lane_to_q;
          res_bad_d = lane_bad_q;
        end else begin
          for (int unsigned i = 0; i < LANES; i++) begin
            if (!done_q[i]) begin
              // Termination tests come before stepping, in this order:
              // zero input, reached 1, step limit exhausted.
              if (x_q[i] == '0) begin
                lane_bad_d[i] = 1'b1;
                done_d[i]     = 1'b1;
              end else if (x_q[i] == WIDTH'(1)) begin
                done_d[i] = 1'b1;
              end else if (cnt_q[i] == MAX_CNT) begin
                lane_to_d[i] = 1'b1;
                done_d[i]    = 1'b1;
              end else if (!x_q[i][0]) begin
                x_d[i]   = x_q[i] >> 1;
                cnt_d[i] = cnt_q[i] + STEP_W'(1);
              end else begin
                // 3x+1 at WIDTH+2 bits; any carry into the top two bits means
                // the result no longer fits the lane.
                odd_next = {2'b00, x_q[i]} + {1'b0, x_q[i], 1'b0} + (WIDTH+2)'(1);
                if (odd_next[WIDTH+1:WIDTH] != 2'b00) begin
                  lane_ovf_d[i] = 1'b1;
                  done_d[i]     = 1'b1;
                end else begin
`ifdef COLLATZ_SHORTCUT_EN
                  x_d[i]   = WIDTH'(odd_next >> 1);
                  cnt_d[i] = (cnt_q[i] >= MAX_CNT - STEP_W'(1)) ? MAX_CNT
                                                                : cnt_q[i] + STEP_W'(2);
`else
                  x_d[i]   = odd_next[WIDTH-1:0];
                  cnt_d[i] = cnt_q[i] + STEP_W'(1);
`endif
                end
              end
            end
          end
        end
      end

      default: state_d = IDLE;
    endcase

    ready_d = (state_d != RUN);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      ready_q    <= 1'b1;
      finish_q   <= 1'b0;
      x_q        <= '0;
      cnt_q      <= '0;
      done_q     <= '0;
      lane_ovf_q <= '0;
      lane_to_q  <= '0;
      lane_bad_q <= '0;
      res_cnt_q  <= '0;
      res_ovf_q  <= '0;
      res_to_q   <= '0;
      res_bad_q  <= '0;
    end else begin
      state_q    <= state_d;
      ready_q    <= ready_d;
      finish_q   <= finish_d;
      x_q        <= x_d;
      cnt_q      <= cnt_d;
      done_q     <= done_d;
      lane_ovf_q <= lane_ovf_d;
      lane_to_q  <= lane_to_d;
      lane_bad_q <= lane_bad_d;
      res_cnt_q  <= res_cnt_d;
      res_ovf_q  <= res_ovf_d;
      res_to_q   <= res_to_d;
      res_bad_q  <= res_bad_d;
    end
  end

  assign ready      = ready_q;
  assign finish     = finish_q;
  assign return_val = res_cnt_q;
  assign ovf        = res_ovf_q;
  assign timeout    = res_to_q;
  assign bad_in     = res_bad_q;

endmodule

// File: tb/tb_collatz_engine.sv
// Testbench for collatz_engine: a default-parameter instance driven through a
// scoreboard, plus a WIDTH=8 instance (overflow) and a MAX_STEPS=100 instance
// (step limit).
module tb_collatz_engine;

  localparam int unsigned L  = 4;
  localparam int unsigned SW = 11;  // clog2(1024+1)
  localparam int unsigned SC = 7;   // clog2(100+1)

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  // Instance A: default parameters
  logic            start_a, ready_a, finish_a;
  logic [L*32-1:0] n_a;
  logic [L*SW-1:0] rv_a;
  logic [L-1:0]    ovf_a, to_a, bad_a;

  collatz_engine #(.WIDTH(32), .LANES(L), .MAX_STEPS(1024)) dut (
    .clk(clk), .reset(reset), .start(start_a), .ready(ready_a), .n(n_a),
    .finish(finish_a), .return_val(rv_a), .ovf(ovf_a), .timeout(to_a), .bad_in(bad_a)
  );

  // Instance B: 8-bit lanes
  logic            start_b, ready_b, finish_b;
  logic [L*8-1:0]  n_b;
  logic [L*SW-1:0] rv_b;
  logic [L-1:0]    ovf_b, to_b, bad_b;

  collatz_engine #(.WIDTH(8), .LANES(L), .MAX_STEPS(1024)) dut_w8 (
    .clk(clk), .reset(reset), .start(start_b), .ready(ready_b), .n(n_b),
    .finish(finish_b), .return_val(rv_b), .ovf(ovf_b), .timeout(to_b), .bad_in(bad_b)
  );

  // Instance C: 100-step limit
  logic            start_c, ready_c, finish_c;
  logic [L*32-1:0] n_c;
  logic [L*SC-1:0] rv_c;
  logic [L-1:0]    ovf_c, to_c, bad_c;

  collatz_engine #(.WIDTH(32), .LANES(L), .MAX_STEPS(100)) dut_m100 (
    .clk(clk), .reset(reset), .start(start_c), .ready(ready_c), .n(n_c),
    .finish(finish_c), .return_val(rv_c), .ovf(ovf_c), .timeout(to_c), .bad_in(bad_c)
  );

  int unsigned checks = 0;
  int unsigned failures = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [63:0] rv;
    logic [3:0]  ovf;
    logic [3:0]  to;
    logic [3:0]  bad;
    int unsigned lat;
    int unsigned acc;
  } exp_t;

  // Reference behaviour of one lane; iters is the number of RUN cycles spent
  // stepping before the terminating cycle.
  function automatic void lane_model(input longint unsigned v, input int unsigned w,
                                     input int unsigned maxs, output int unsigned cnt,
                                     output bit o, output bit t, output bit b,
                                     output int unsigned iters);
    longint unsigned x;
    longint unsigned lim;
    x = v;
    lim = 64'd1 << w;
    cnt = 0; o = 1'b0; t = 1'b0; b = 1'b0; iters = 0;
    if (v == 0) begin
      b = 1'b1;
      return;
    end
    while (x != 1) begin
      if (cnt == maxs) begin
        t = 1'b1;
        return;
      end
      if (x % 2 == 0) begin
        x = x / 2;
        cnt = cnt + 1;
      end else if (3 * x + 1 >= lim) begin
        o = 1'b1;
        return;
      end else begin
`ifdef COLLATZ_SHORTCUT_EN
        x = (3 * x + 1) / 2;
        cnt = (cnt + 2 > maxs) ? maxs : cnt + 2;
`else
        x = 3 * x + 1;
        cnt = cnt + 1;
`endif
      end
      iters = iters + 1;
    end
  endfunction

  function automatic exp_t compute_exp(input logic [127:0] nv, input int unsigned w,
                                       input int unsigned maxs, input int unsigned sw);
    exp_t e;
    int unsigned c, it, mx;
    bit o, t, b;
    longint unsigned lv;
    e.rv = '0; e.ovf = '0; e.to = '0; e.bad = '0; e.acc = 0;
    mx = 0;
    for (int i = 0; i < 4; i++) begin
      lv = 64'(nv >> (i * w)) & ((64'd1 << w) - 64'd1);
      lane_model(lv, w, maxs, c, o, t, b, it);
      e.rv = e.rv | (64'(c) << (i * sw));
      e.ovf[i] = o;
      e.to[i]  = t;
      e.bad[i] = b;
      if (it > mx) mx = it;
    end
    e.lat = mx + 2;
    return e;
  endfunction

  // Scoreboard for instance A. Inputs change only just after a rising edge,
  // so at the falling edge start/ready show what the next edge will sample.
  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  exp_t        exp_q[$];
  exp_t        mon_e;
  int unsigned accepts = 0;
  int unsigned fins = 0;
  logic        prev_fin = 1'b0;
  logic [L*SW-1:0] last_rv = '0;
  logic [3:0]  last_ovf = '0, last_to = '0, last_bad = '0;
  int unsigned last_lat = 0;

  always @(negedge clk) begin
    if (finish_a) begin
      check("fin_one_cycle", 64'(prev_fin), 64'd0);
      if (exp_q.size() == 0) begin
        check("unexpected_finish", 64'd1, 64'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("sb_rv", 64'(rv_a), mon_e.rv);
        check("sb_ovf", 64'(ovf_a), 64'(mon_e.ovf));
        check("sb_timeout", 64'(to_a), 64'(mon_e.to));
        check("sb_bad_in", 64'(bad_a), 64'(mon_e.bad));
        check("sb_latency", 64'(cyc - mon_e.acc), 64'(mon_e.lat));
        last_rv  = rv_a;
        last_ovf = ovf_a;
        last_to  = to_a;
        last_bad = bad_a;
        last_lat = cyc - mon_e.acc;
      end
      fins++;
    end
    if (reset && start_a && ready_a) begin
      mon_e = compute_exp(n_a, 32, 1024, SW);
      mon_e.acc = cyc + 1;
      exp_q.push_back(mon_e);
      accepts++;
    end
    prev_fin = finish_a;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic call_a(input logic [127:0] v);
    int unsigned k;
    k = 0;
    while (!ready_a && k < 5000) begin
      step();
      k++;
    end
    if (!ready_a) check("ready_wait", 64'd0, 64'd1);
    n_a = v;
    start_a = 1'b1;
    step();
    start_a = 1'b0;
  endtask

  task automatic drain_a();
    int unsigned k;
    k = 0;
    while (exp_q.size() != 0 && k < 8000) begin
      step();
      k++;
    end
    check("drain_bound", 64'(exp_q.size()), 64'd0);
  endtask

  function automatic logic [127:0] rand_call();
    logic [127:0] v;
    for (int i = 0; i < 4; i++) v[i*32 +: 32] = 32'($urandom_range(1, 99999));
    return v;
  endfunction

  logic [127:0] vals [5];
  exp_t        e_side;
  int unsigned lat, f0, a0, k;

  initial begin
    start_a = 1'b0; n_a = '0;
    start_b = 1'b0; n_b = '0;
    start_c = 1'b0; n_c = '0;
    reset = 1'b0;
    repeat (3) step();

    // Reset state
    check("rst_finish", 64'(finish_a), 64'd0);
    check("rst_rv", 64'(rv_a), 64'd0);
    check("rst_flags", 64'({ovf_a, to_a, bad_a}), 64'd0);
    reset = 1'b1;
    step();
    check("rst_ready", 64'(ready_a), 64'd1);

    // Golden example {27,1,6,7}
    call_a({32'd7, 32'd6, 32'd1, 32'd27});
    check("run_ready_low", 64'(ready_a), 64'd0);
    drain_a();
    check("g1_rv", 64'(last_rv), 64'({11'd16, 11'd8, 11'd0, 11'd111}));
    check("g1_flags", 64'({last_ovf, last_to, last_bad}), 64'd0);
`ifndef COLLATZ_SHORTCUT_EN
    check("g1_latency", 64'(last_lat), 64'd113);
`endif

    // Zero input lane {0,2,1,3}
    call_a({32'd3, 32'd1, 32'd2, 32'd0});
    drain_a();
    check("g2_bad_in", 64'(last_bad), 64'h1);
    check("g2_rv", 64'(last_rv), 64'({11'd7, 11'd0, 11'd1, 11'd0}));

    // Boundaries: immediate overflow, long even run, n=1, small even
    call_a({32'hFFFF_FFFF, 32'h8000_0000, 32'd1, 32'd2});
    drain_a();
    check("bnd_ovf", 64'(last_ovf), 64'h8);

    // All lanes at 1: minimum latency
    call_a({32'd1, 32'd1, 32'd1, 32'd1});
    drain_a();
    check("min_latency", 64'(last_lat), 64'd2);

    for (int r = 0; r < 4; r++) begin
      call_a(rand_call());
      drain_a();
    end

    // start held high across five calls
    vals[0] = {32'd7, 32'd6, 32'd1, 32'd27};
    vals[1] = {32'd3, 32'd1, 32'd2, 32'd0};
    vals[2] = rand_call();
    vals[3] = {32'd1, 32'd1, 32'd1, 32'd1};
    vals[4] = rand_call();
    f0 = fins;
    a0 = accepts;
    n_a = vals[0];
    start_a = 1'b1;
    for (int c = 0; c < 5; c++) begin
      k = 0;
      while (accepts < a0 + c + 1 && k < 3000) begin
        step();
        k++;
      end
      if (c < 4) n_a = vals[c+1];
      else start_a = 1'b0;
    end
    drain_a();
    check("b2b_accepts", 64'(accepts - a0), 64'd5);
    check("b2b_finishes", 64'(fins - f0), 64'd5);

    // Reset in the middle of a call
    call_a({32'd7, 32'd6, 32'd1, 32'd27});
    repeat (30) step();
    reset = 1'b0;
    exp_q.delete();
    step();
    reset = 1'b1;
    check("abort_finish", 64'(finish_a), 64'd0);
    check("abort_rv", 64'(rv_a), 64'd0);
    check("abort_flags", 64'({ovf_a, to_a, bad_a}), 64'd0);
    check("abort_ready", 64'(ready_a), 64'd1);
    f0 = fins;
    repeat (150) step();
    check("abort_no_finish", 64'(fins - f0), 64'd0);
    call_a({32'd7, 32'd6, 32'd1, 32'd27});
    drain_a();
    check("post_rst_rv", 64'(last_rv), 64'({11'd16, 11'd8, 11'd0, 11'd111}));
`ifndef COLLATZ_SHORTCUT_EN
    check("post_rst_latency", 64'(last_lat), 64'd113);
`endif

    // 8-bit lanes: lane 0 overflows, others complete
    n_b = {8'd5, 8'd1, 8'd6, 8'd27};
    e_side = compute_exp(128'(n_b), 8, 1024, SW);
    start_b = 1'b1;
    step();
    start_b = 1'b0;
    lat = 0;
    do begin
      step();
      lat++;
    end while (!finish_b && lat < 3000);
    check("w8_finish", 64'(finish_b), 64'd1);
    check("w8_rv", 64'(rv_b), e_side.rv);
    check("w8_ovf", 64'(ovf_b), 64'(e_side.ovf));
    check("w8_ovf_gold", 64'(ovf_b), 64'h1);
    check("w8_other_flags", 64'({to_b, bad_b}), 64'd0);
    check("w8_latency", 64'(lat), 64'(e_side.lat));

    // 100-step limit: 27 times out
    n_c = {32'd7, 32'd6, 32'd1, 32'd27};
    e_side = compute_exp(n_c, 32, 100, SC);
    start_c = 1'b1;
    step();
    start_c = 1'b0;
    lat = 0;
    do begin
      step();
      lat++;
    end while (!finish_c && lat < 3000);
    check("m100_finish", 64'(finish_c), 64'd1);
    check("m100_rv", 64'(rv_c), e_side.rv);
    check("m100_rv_gold", 64'(rv_c[SC-1:0]), 64'd100);
    check("m100_timeout", 64'(to_c), 64'h1);
    check("m100_other_flags", 64'({ovf_c, bad_c}), 64'd0);
    check("m100_latency", 64'(lat), 64'(e_side.lat));
`ifndef COLLATZ_SHORTCUT_EN
    check("m100_latency_gold", 64'(lat), 64'd102);
`endif

    repeat (3) step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
